// File: rtl/serial_word_matcher_pkg.sv
// Shared definitions for the serial word matcher: state encoding,
// default sizing and a helper for the fill counter width.
package serial_word_matcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 5;
    localparam int DEFAULT_CNT_W = 8;

    // Fill counter needs to hold 0..WIDTH-1 with one spare bit of headroom.
    function automatic int fill_cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_word_matcher_if.sv
// Bundles the serial input, control strobes and match results of the
// serial word matcher. The master side drives the bit stream and control;
// the slave side is the matcher itself.
interface serial_word_matcher_if #(
    parameter int WIDTH = serial_word_matcher_pkg::DEFAULT_WIDTH,
    parameter int CNT_W = serial_word_matcher_pkg::DEFAULT_CNT_W
);
    logic             load;
    logic [WIDTH-1:0] pattern_in;
    logic             bit_valid;
    logic             bit_in;
    logic             clear;
    logic             armed;
    logic [WIDTH-1:0] window;
    logic             match;
    logic [CNT_W-1:0] match_count;

    modport master (
        output load, pattern_in, bit_valid, bit_in, clear,
        input  armed, window, match, match_count
    );

    modport slave (
        input  load, pattern_in, bit_valid, bit_in, clear,
        output armed, window, match, match_count
    );
endinterface

// File: rtl/serial_word_matcher_word_eq.sv
// Combinational WIDTH-bit equality: per-bit XNOR folded by an AND reduce.
module word_eq #(
    parameter int WIDTH = serial_word_matcher_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             eq
);
    logic [WIDTH-1:0] bit_same;

    // A bit agrees when both sides carry the same value; the word agrees when all bits do.
    always_comb begin
        bit_same = ~(a ^ b);
        eq       = &bit_same;
    end
endmodule

// File: rtl/serial_word_matcher.sv
// Bit-serial front end: shifts valid bits into a WIDTH-bit window and
// compares the post-shift window against a loaded pattern. A match is
// only reported once WIDTH bits have arrived since the last load, so a
// freshly cleared window cannot alias an all-zero pattern.
module serial_word_matcher
    import serial_word_matcher_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_word_matcher_if.slave bus
);
    localparam int FILL_W = fill_cnt_width(WIDTH);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  pattern_q;
    logic [WIDTH-1:0]  window_q;
    logic [FILL_W-1:0] fill_cnt_q;
    logic              match_q;
    logic [CNT_W-1:0]  count_q;

    logic [WIDTH-1:0]  next_window;
    logic              window_eq;
    logic              shift_en;
    logic              fill_done;
    logic              match_next;

    // The comparator always looks at the window as it will be after this bit lands.
    word_eq #(.WIDTH(WIDTH)) u_word_eq (
        .a  (next_window),
        .b  (pattern_q),
        .eq (window_eq)
    );

    // Next-state and shift/compare decode; load overrides everything and drops any bit.
    always_comb begin
        next_state  = state;
        next_window = {window_q[WIDTH-2:0], bus.bit_in};
        shift_en    = 1'b0;
        fill_done   = 1'b0;
        match_next  = 1'b0;

        if (bus.load) begin
            next_state = FILL;
        end else if (bus.bit_valid && (state != IDLE)) begin
            shift_en  = 1'b1;
            fill_done = (state == FILL) && (fill_cnt_q == FILL_LAST);
            if (fill_done) begin
                next_state = RUN;
            end
            match_next = window_eq && ((state == RUN) || fill_done);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Pattern latch, shift window and fill progress since the last load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern_q  <= '0;
            window_q   <= '0;
            fill_cnt_q <= '0;
        end else if (bus.load) begin
            pattern_q  <= bus.pattern_in;
            window_q   <= '0;
            fill_cnt_q <= '0;
        end else if (shift_en) begin
            window_q <= next_window;
            if (state == FILL) begin
                fill_cnt_q <= fill_cnt_q + 1'b1;
            end
        end
    end

    // Registered match pulse and saturating match counter; clear beats the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_q <= 1'b0;
            count_q <= '0;
        end else begin
            match_q <= match_next;
            if (bus.clear) begin
                count_q <= '0;
            end else if (match_next && (count_q != CNT_MAX)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    // Outputs come straight from registers; armed is a pure state decode.
    always_comb begin
        bus.armed       = (state == FILL) || (state == RUN);
        bus.window      = window_q;
        bus.match       = match_q;
        bus.match_count = count_q;
    end
endmodule
